// File: rtl/ema_sma_pkg.sv
// Shared constants and types for the SMA/EMA datapath and its stimulus player.
package ema_sma_pkg;

  localparam int PRICE_W          = 4;
  localparam int TICK_DIV_DEFAULT = 50_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } player_state_t;

endpackage

// File: rtl/tick_gen.sv
// Cadence counter: counts 0..TICK_DIV-1 while enabled and flags the last count.
// clear restarts the period; the tick is a one-cycle pulse at the terminal count.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Period counter, wraps at LAST and restarts on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/price_feed_player.sv
// Replays a user-loaded sequence of price samples as strobe+data at a fixed cadence.
//
// state | meaning
// IDLE  | sequence may be loaded/cleared; start with a non-empty sequence begins playback
// PLAY  | one sample emitted immediately, then one every TICK_DIV cycles
module price_feed_player
  import ema_sma_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int PRICE_W  = ema_sma_pkg::PRICE_W,
  parameter int TICK_DIV = ema_sma_pkg::TICK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PRICE_W-1:0] wr_data,
  input  logic               clr,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic               sample_valid,
  output logic [PRICE_W-1:0] sample_data,
  output logic               busy,
  output logic [ADDR_W-1:0]  play_idx,
  output logic [ADDR_W:0]    count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  player_state_t state_q, state_d;

  logic [PRICE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  idx_q;
  logic               first_q;
  logic               tick;

  logic start_ok;
  logic stop_now;
  logic due;
  logic last;
  logic wr_ok;

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    stop_now = 1'b0;
    due      = 1'b0;
    last     = ({1'b0, idx_q} == (count - (ADDR_W + 1)'(1)));
    wr_ok    = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ok    = wr_en && !clr && (count < DEPTH_C);
        start_ok = start && (count != '0);
        if (start_ok) state_d = PLAY;
      end
      PLAY: begin
        stop_now = stop;
        // stop beats a due emission: no strobe on that edge
        due = (first_q || tick) && !stop;
        if (stop_now) state_d = IDLE;
        else if (due && last && !loop_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sequence length, playback pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      play_idx     <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= due;
      // busy follows PLAY but lags entry by one edge so it rises with the first strobe
      busy         <= (state_q == PLAY) && (state_d == PLAY);
      if (state_q == IDLE) begin
        if (clr)        count <= '0;
        else if (wr_ok) count <= count + (ADDR_W + 1)'(1);
      end
      if (start_ok) begin
        idx_q   <= '0;
        first_q <= 1'b1;
      end
      if (stop_now) first_q <= 1'b0;
      if (due) begin
        sample_data <= mem[idx_q];
        play_idx    <= idx_q;
        first_q     <= 1'b0;
        idx_q       <= last ? '0 : idx_q + ADDR_W'(1);
      end
    end
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[ADDR_W-1:0]] <= wr_data;
  end

  // Cadence restarts on every emission, on entry to PLAY and on abort.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(start_ok || due || stop_now),
    .en   (state_q == PLAY),
    .tick (tick)
  );

endmodule

// File: doc/price_feed_player.md
# price_feed_player

Programmable stimulus source for the SMA/EMA datapath. Holds a user-loaded sequence of 4-bit price samples and replays it at a fixed cadence. Each sample appears as a one-cycle strobe plus data, in the same form moving_avg takes from the switch/key path (sample_data → sw_in, sample_valid → key_pressed). It sits in top between the board inputs and moving_avg, so the averaging and signal logic can be exercised with repeatable price series.

## Interface
Parameters:
- DEPTH, 16, number of sample entries (power of two)
- ADDR_W, 4, log2(DEPTH)
- PRICE_W, 4, sample width
- TICK_DIV, 50_000_000, clk cycles between successive sample strobes (≥2)

Ports:
- clk  in  1  system clock (CLOCK_50 domain); one clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  single-cycle strobe: append wr_data to sequence
- wr_data  in  PRICE_W  sample to append
- clr  in  1  single-cycle strobe: empty the sequence
- start  in  1  single-cycle strobe: begin playback
- stop  in  1  single-cycle strobe: abort playback
- loop_en  in  1  level: wrap to entry 0 after last entry
- sample_valid  out  1  one-cycle strobe, a new sample is on sample_data
- sample_data  out  PRICE_W  last emitted sample, held between strobes
- busy  out  1  high while in PLAY
- play_idx  out  ADDR_W  index of the most recently emitted entry
- count  out  ADDR_W+1  number of loaded entries, 0..DEPTH

## Operation
- States: IDLE, PLAY.
- Reset, async: state=IDLE, count=0, play_idx=0, sample_data=0, sample_valid=0, busy=0, tick counter=0. Buffer contents are don't-care.
- IDLE:
  - wr_en with count<DEPTH: entry[count]←wr_data, count+1.
  - wr_en with count==DEPTH: ignored, no wrap.
  - clr: count←0. clr and wr_en in the same cycle: clr wins, no write.
  - start with count>0: →PLAY.
  - start with count==0: ignored.
- PLAY:
  - wr_en, clr and start are ignored.
  - Each emission: sample_data←entry[idx], play_idx←idx, sample_valid=1 for exactly one cycle.
  - After emitting idx==count-1: if loop_en, next idx=0 and stay in PLAY. Otherwise →IDLE in the same cycle as that last strobe. loop_en is sampled at that moment.
  - stop: →IDLE on the next edge, tick counter cleared, no further strobes. stop in the same cycle as a due emission: stop wins, no strobe.
- sample_data and play_idx keep their last values in IDLE.

## Timing
- start accepted at edge N → first strobe (entry 0) registered at edge N+1.
- Later strobes every TICK_DIV cycles: strobe k at edge N+1+k·TICK_DIV.
- Tick counter counts 0..TICK_DIV-1 and resets on each strobe and on entry to PLAY.
- busy rises at edge N+1 and falls at the edge that registers the final strobe (non-loop). That strobe cycle is therefore the first cycle with busy=0.
- All outputs registered. No combinational path from inputs to outputs.
- Reset asserted mid-PLAY: outputs go to reset values immediately, and a pending strobe is lost.

## Structure
- Shared package ema_sma_pkg holds:
  - PRICE_W = 4
  - the player state enum (IDLE, PLAY)
  - the default TICK_DIV constant
- Sub-module tick_gen (parameter TICK_DIV; inputs clk, rst, clear, en; output one-cycle tick). It carries the cadence counter, reused for key auto-repeat later.
- Sample storage is a plain register array inside price_feed_player; no RAM macro.

## Test plan
Bench uses TICK_DIV=4, DEPTH=16.
1. Load 3, 7, 12; start, loop_en=0 → strobes at +1, +5, +9 cycles carrying 3, 7, 12 with play_idx 0, 1, 2; busy=0 from the third strobe on; sample_data holds 12.
2. Same load, loop_en=1 → strobe sequence 3, 7, 12, 3, 7 at 4-cycle spacing. stop asserted on the cycle a strobe is due → no strobe, IDLE next edge, busy=0.
3. Write 17 values → count=16; 17th ignored; playback emits exactly 16 samples. clr+wr_en together → count=0, no write.
4. start with count=0 → busy stays 0, no strobe. wr_en/clr/start during PLAY → count and sequence unchanged.
5. Reset asserted between strobe 1 and 2 → all outputs zero asynchronously, no further strobes after release.
6. Integration with moving_avg, sequence 0, 15 looped → moving_avg receives alternating samples; avg and ema match the golden model after 8 strobes.
